// File: rtl/hft_ui_pkg.sv
// Shared types and widths for the front-panel button/step logic.
// Pulled in by the step controller top.
package hft_ui_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } btn_state_t;

  localparam int PRESS_CNT_W = 16;
  localparam int DROP_CNT_W  = 8;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer plus stable-level debounce counter.
// Reusable for any slow asynchronous switch or button input.
module sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic in,
  output logic level,
  output logic toggle
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q;
  logic          s2_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // toggle is the pre-edge strobe so callers can register with level
  always_comb begin
    cnt_d  = '0;
    toggle = 1'b0;
    if (s2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        toggle = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q  <= in;
      s2_q  <= s1_q;
      cnt_q <= cnt_d;
      if (toggle) begin
        level_q <= ~level_q;
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/btn_step_ctrl.sv
// Manual-step button conditioner: debounce, press/auto-repeat FSM,
// valid/ready step output with press and drop counters.
module btn_step_ctrl
  import hft_ui_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   btn_in,
  input  logic                   enable,
  input  logic                   step_ready,
  output logic                   step_valid,
  output logic                   btn_level,
  output logic [PRESS_CNT_W-1:0] press_count,
  output logic [DROP_CNT_W-1:0]  drop_count
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW =
    (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST =
    RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam bit REP_EN = (REPEAT_CYCLES != 0);

  logic lvl;
  logic tog;
  logic rise;
  logic fall;

  sync_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in        (btn_in),
    .level     (lvl),
    .toggle    (tog)
  );

  assign rise = tog & ~lvl;
  assign fall = tog & lvl;

  btn_state_t state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rep_q, rep_d;
  logic rise_ev;
  logic rep_ev;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rep_d   = rep_q;
    rise_ev = 1'b0;
    rep_ev  = 1'b0;
    unique case (state_q)
      IDLE: begin
        hold_d = '0;
        rep_d  = '0;
        if (rise) begin
          state_d = HOLD;
          rise_ev = 1'b1;
        end
      end
      HOLD: begin
        if (fall) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (hold_q == HOLD_LAST) begin
          // without auto-repeat the timer parks here until release
          if (REP_EN) begin
            state_d = REPEAT;
            rep_ev  = 1'b1;
            hold_d  = '0;
            rep_d   = '0;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      REPEAT: begin
        if (fall) begin
          state_d = IDLE;
          rep_d   = '0;
        end else if (rep_q == REP_LAST) begin
          rep_ev = 1'b1;
          rep_d  = '0;
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic                   ev;
  logic                   valid_q, valid_d;
  logic [PRESS_CNT_W-1:0] press_q, press_d;
  logic [DROP_CNT_W-1:0]  drop_q, drop_d;

  assign ev = enable & (rise_ev | rep_ev);

  always_comb begin
    valid_d = valid_q;
    press_d = press_q;
    drop_d  = drop_q;
    if (ev) begin
      if (valid_q && !step_ready) begin
        if (drop_q != '1) begin
          drop_d = drop_q + 1'b1;
        end
      end else begin
        valid_d = 1'b1;
        if (rise_ev) begin
          press_d = press_q + 1'b1;
        end
      end
    end else if (valid_q && step_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      rep_q   <= '0;
      valid_q <= 1'b0;
      press_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rep_q   <= rep_d;
      valid_q <= valid_d;
      press_q <= press_d;
      drop_q  <= drop_d;
    end
  end

  assign step_valid  = valid_q;
  assign btn_level   = lvl;
  assign press_count = press_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_btn_step_ctrl.sv
// Scoreboard bench for btn_step_ctrl: stimulus queues expected
// step acceptances, a monitor pops them on each handshake.
module tb_btn_step_ctrl;

  logic        sys_clk    = 1'b0;
  logic        sys_rst_n  = 1'b0;
  logic        btn_in     = 1'b0;
  logic        enable     = 1'b1;
  logic        step_ready = 1'b1;
  logic        step_valid;
  logic        btn_level;
  logic [15:0] press_count;
  logic [7:0]  drop_count;

  btn_step_ctrl #(
    .DEBOUNCE_CYCLES (8),
    .HOLD_CYCLES     (40),
    .REPEAT_CYCLES   (10)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .btn_in      (btn_in),
    .enable      (enable),
    .step_ready  (step_ready),
    .step_valid  (step_valid),
    .btn_level   (btn_level),
    .press_count (press_count),
    .drop_count  (drop_count)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int cyc;
    int press;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input int c, input int p);
    exp_t e;
    e.cyc   = c;
    e.press = p;
    sb.push_back(e);
  endtask

  task automatic press(input int hi, input int lo);
    btn_in = 1'b1;
    tick(hi);
    btn_in = 1'b0;
    tick(lo);
  endtask

  // monitor: every accepted step must match the next queued expectation
  always @(negedge sys_clk) begin
    if (sys_rst_n && step_valid && step_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_step: got step at cycle %0d, required none",
                 cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("step_cycle", cyc, e.cyc);
        if (e.press >= 0) check("step_press_count", press_count, e.press);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;

    sys_rst_n = 1'b0;
    tick(3);
    check("rst_valid", step_valid, 0);
    check("rst_level", btn_level, 0);
    check("rst_press", press_count, 0);
    check("rst_drop", drop_count, 0);
    sys_rst_n = 1'b1;
    tick(2);

    // clean press
    t = cyc;
    push(t + 10, 1);
    btn_in = 1'b1;
    tick(9);
    check("clean_level_early", btn_level, 0);
    tick(1);
    check("clean_level_rise", btn_level, 1);
    tick(20);
    btn_in = 1'b0;
    tick(20);
    check("clean_level_fall", btn_level, 0);
    check("clean_press", press_count, 1);
    check("clean_drop", drop_count, 0);
    check("clean_valid", step_valid, 0);

    // bounce then settle high
    for (int i = 0; i < 10; i++) begin
      btn_in = (i % 2 == 0);
      tick(3);
    end
    check("bounce_level", btn_level, 0);
    t = cyc;
    push(t + 10, 2);
    btn_in = 1'b1;
    tick(30);
    btn_in = 1'b0;
    tick(20);
    check("bounce_press", press_count, 2);

    // long hold with auto-repeat
    t = cyc;
    push(t + 10, 3);
    for (int k = 0; k < 6; k++) push(t + 50 + 10 * k, 3);
    btn_in = 1'b1;
    tick(100);
    btn_in = 1'b0;
    tick(20);
    check("hold_press", press_count, 3);
    check("hold_level", btn_level, 0);

    // stepping disabled
    enable = 1'b0;
    btn_in = 1'b1;
    tick(10);
    check("dis_level", btn_level, 1);
    check("dis_valid", step_valid, 0);
    tick(20);
    btn_in = 1'b0;
    tick(20);
    check("dis_valid_end", step_valid, 0);
    check("dis_press", press_count, 3);
    enable = 1'b1;

    // backpressure
    step_ready = 1'b0;
    press(20, 20);
    press(20, 20);
    press(20, 20);
    check("bp_valid_held", step_valid, 1);
    check("bp_drop", drop_count, 2);
    step_ready = 1'b1;
    push(cyc, -1);
    tick(1);
    check("bp_valid_clear", step_valid, 0);
    check("bp_drop_after", drop_count, 2);
    tick(5);

    // reset in the middle of debouncing
    btn_in = 1'b1;
    tick(4);
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", step_valid, 0);
    check("mid_rst_level", btn_level, 0);
    check("mid_rst_press", press_count, 0);
    check("mid_rst_drop", drop_count, 0);
    tick(3);
    sys_rst_n = 1'b1;
    t = cyc;
    push(t + 10, 1);
    tick(9);
    check("post_rst_level_early", btn_level, 0);
    tick(1);
    check("post_rst_level_rise", btn_level, 1);
    check("post_rst_press", press_count, 1);
    tick(5);
    btn_in = 1'b0;
    tick(20);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
